param_sram_ctrl: RTL and testbench

- Parametrised successor to the fixed 1024x8 single-port memory: generic width and depth behind a request/ready handshake.
- Adds a hardware clear sequencer. On reset release, or on command, it zeroes every location before accepting traffic.
- Read data is registered and qualified by a one-cycle valid pulse. Out-of-range addresses are flagged.
- Sits between a bus-side master (bench tasks or a future bus bridge) and the storage array.

---
 rtl/param_sram_ctrl.sv | 143 ++++++++++++++
 tb/tb_param_sram_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/param_sram_ctrl.sv
// Parametrised single-port SRAM controller with a hardware clear sequencer and req/ready handshake.
// Define SRAM_PARITY_EN to add a stored even-parity bit per word and the parity_err output.
module param_sram_ctrl #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clear_req,
    output logic              ready,
    output logic              init_busy,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              addr_err
`ifdef SRAM_PARITY_EN
    ,
    output logic              parity_err
`endif
);

`ifdef SRAM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    if ((DATA_W < 1) || (DEPTH < 2)) begin : g_param_chk
        $error("param_sram_ctrl: DATA_W must be >= 1 and DEPTH >= 2");
    end
    if ((ADDR_W < 31) && (DEPTH > (1 << ADDR_W))) begin : g_addr_chk
        $error("param_sram_ctrl: 2**ADDR_W must be >= DEPTH");
    end

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [MEM_W-1:0]  mem [DEPTH];
    logic              in_range;
    logic [MEM_W-1:0]  rd_word;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [MEM_W-1:0]  mem_wdata;

`ifdef SRAM_PARITY_EN
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`endif

    function automatic logic [MEM_W-1:0] pack_word(input logic [DATA_W-1:0] d);
`ifdef SRAM_PARITY_EN
        return {even_parity(d), d};
`else
        return d;
`endif
    endfunction

    assign in_range = {1'b0, address} < DEPTH_X;
    assign rd_word  = mem[address];

    // Single write port shared by the clear sequencer and bus writes
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = cnt;
        mem_wdata = '0;
        if (state == CLEAR) begin
            mem_we = 1'b1;
        end else if (req && wr && in_range) begin
            mem_we    = 1'b1;
            mem_waddr = address;
            mem_wdata = pack_word(data_in);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLEAR;
            cnt        <= '0;
            ready      <= 1'b0;
            init_busy  <= 1'b1;
            data_out   <= '0;
            rd_valid   <= 1'b0;
            addr_err   <= 1'b0;
`ifdef SRAM_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            rd_valid   <= 1'b0;
            addr_err   <= 1'b0;
`ifdef SRAM_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                CLEAR: begin
                    // cnt stops at the last index, so DEPTH == 2**ADDR_W never wraps
                    if (cnt == LAST_IDX) begin
                        state     <= READY;
                        ready     <= 1'b1;
                        init_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READY: begin
                    if (req) begin
                        addr_err <= !in_range;
                        if (!wr) begin
                            rd_valid <= 1'b1;
                            data_out <= in_range ? rd_word[DATA_W-1:0] : '0;
`ifdef SRAM_PARITY_EN
                            parity_err <= in_range &&
                                (rd_word[DATA_W] != even_parity(rd_word[DATA_W-1:0]));
`endif
                        end
                    end
                    // An access in the same cycle completes above before the clear begins
                    if (clear_req) begin
                        state     <= CLEAR;
                        cnt       <= '0;
                        ready     <= 1'b0;
                        init_busy <= 1'b1;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_param_sram_ctrl.sv
// Self-checking bench for param_sram_ctrl: DUT A (1024 words) and DUT B (1000 words, ADDR_W 10).
module tb_param_sram_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       a_req, a_wr, a_clr, b_req, b_wr, b_clr;
    logic [9:0] a_addr, b_addr;
    logic [7:0] a_din, b_din, a_dout, b_dout;
    logic       a_ready, a_busy, a_rv, a_err;
    logic       b_ready, b_busy, b_rv, b_err;
`ifdef SRAM_PARITY_EN
    logic       a_perr, b_perr;
`endif

    param_sram_ctrl #(.DATA_W(8), .DEPTH(1024), .ADDR_W(10)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(a_req), .wr(a_wr), .address(a_addr),
        .data_in(a_din), .clear_req(a_clr), .ready(a_ready), .init_busy(a_busy),
        .data_out(a_dout), .rd_valid(a_rv), .addr_err(a_err)
`ifdef SRAM_PARITY_EN
        , .parity_err(a_perr)
`endif
    );

    param_sram_ctrl #(.DATA_W(8), .DEPTH(1000), .ADDR_W(10)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(b_req), .wr(b_wr), .address(b_addr),
        .data_in(b_din), .clear_req(b_clr), .ready(b_ready), .init_busy(b_busy),
        .data_out(b_dout), .rd_valid(b_rv), .addr_err(b_err)
`ifdef SRAM_PARITY_EN
        , .parity_err(b_perr)
`endif
    );

    logic       sel;
    wire        s_ready = sel ? b_ready : a_ready;
    wire        s_busy  = sel ? b_busy  : a_busy;
    wire        s_rv    = sel ? b_rv    : a_rv;
    wire        s_err   = sel ? b_err   : a_err;
    wire  [7:0] s_dout  = sel ? b_dout  : a_dout;

    int n_cmp;
    int n_fail;

    typedef struct {
        bit         rd;
        logic [7:0] data;
        bit         err;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit         b;
        bit         w;
        logic [9:0] addr;
        logic [7:0] d;
        logic [7:0] exp_d;
        bit         exp_err;
    } vec_t;
    vec_t vt[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock; any access accepted at this edge must show up now, otherwise outputs stay quiet
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rd_valid", s_rv, e.rd);
            check("addr_err", s_err, e.err);
            if (e.rd) check("data_out", s_dout, e.data);
        end else begin
            check("rd_valid_idle", s_rv, 1'b0);
            check("addr_err_idle", s_err, 1'b0);
        end
    endtask

    task automatic access(input bit w, input logic [9:0] addr, input logic [7:0] d,
                          input bit clr, input logic [7:0] exp_d, input bit exp_err);
        check("ready_before_access", s_ready, 1'b1);
        if (!sel) begin
            a_req = 1'b1; a_wr = w; a_addr = addr; a_din = d; a_clr = clr;
        end else begin
            b_req = 1'b1; b_wr = w; b_addr = addr; b_din = d; b_clr = clr;
        end
        sb.push_back('{rd: !w, data: exp_d, err: exp_err});
        tick();
        a_req = 1'b0; a_clr = 1'b0; b_req = 1'b0; b_clr = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_a_ready", a_ready, 1'b0);
        check("rst_a_busy",  a_busy,  1'b1);
        check("rst_a_dout",  a_dout,  8'h00);
        check("rst_a_rv",    a_rv,    1'b0);
        check("rst_a_err",   a_err,   1'b0);
        check("rst_b_ready", b_ready, 1'b0);
        check("rst_b_busy",  b_busy,  1'b1);
        check("rst_b_dout",  b_dout,  8'h00);
    endtask

    // Called just after a posedge: release reset and count cycles until each DUT becomes ready
    task automatic release_and_count();
        int na = 0;
        int nb = 0;
        rst_n = 1'b1;
        while ((!a_ready || !b_ready) && na < 3000) begin
            if (!a_ready) begin
                check("a_busy_in_clear", a_busy, 1'b1);
                na++;
            end
            if (!b_ready) nb++;
            tick();
        end
        check("a_clear_cycles", na, 1024);
        check("b_clear_cycles", nb, 1000);
        check("a_busy_after_clear", a_busy, 1'b0);
    endtask

    task automatic wait_ready(input string name, input int exp_n);
        int n = 0;
        while (!s_ready && n < 3000) begin
            n++;
            tick();
        end
        check(name, n, exp_n);
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; sel = 1'b0;
        rst_n = 1'b0;
        a_req = 0; a_wr = 0; a_clr = 0; a_addr = '0; a_din = '0;
        b_req = 0; b_wr = 0; b_clr = 0; b_addr = '0; b_din = '0;

        vt[0]  = '{0, 0, 10'd0,    8'h00, 8'h00, 0};
        vt[1]  = '{0, 0, 10'd511,  8'h00, 8'h00, 0};
        vt[2]  = '{0, 0, 10'd1023, 8'h00, 8'h00, 0};
        vt[3]  = '{0, 1, 10'd5,    8'hA5, 8'h00, 0};
        vt[4]  = '{0, 0, 10'd5,    8'h00, 8'hA5, 0};
        vt[5]  = '{0, 1, 10'd3,    8'h11, 8'h00, 0};
        vt[6]  = '{0, 0, 10'd3,    8'h00, 8'h11, 0};
        vt[7]  = '{0, 1, 10'd3,    8'h22, 8'h00, 0};
        vt[8]  = '{0, 0, 10'd3,    8'h00, 8'h22, 0};
        vt[9]  = '{0, 1, 10'd1023, 8'h3C, 8'h00, 0};
        vt[10] = '{0, 0, 10'd1023, 8'h00, 8'h3C, 0};
        vt[11] = '{0, 0, 10'd5,    8'h00, 8'hA5, 0};
        vt[12] = '{0, 1, 10'd7,    8'h5A, 8'h00, 0};
        vt[13] = '{0, 0, 10'd7,    8'h00, 8'h5A, 0};
        vt[14] = '{1, 1, 10'd1000, 8'hFF, 8'h00, 1};
        vt[15] = '{1, 0, 10'd1000, 8'h00, 8'h00, 1};
        vt[16] = '{1, 1, 10'd999,  8'h77, 8'h00, 0};
        vt[17] = '{1, 0, 10'd999,  8'h00, 8'h77, 0};
        vt[18] = '{1, 0, 10'd0,    8'h00, 8'h00, 0};
        vt[19] = '{1, 0, 10'd1000, 8'h00, 8'h00, 1};

        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        release_and_count();

        // Back-to-back table traffic, no idle cycles between entries
        foreach (vt[i]) begin
            sel = vt[i].b;
            access(vt[i].w, vt[i].addr, vt[i].d, 1'b0, vt[i].exp_d, vt[i].exp_err);
        end
        sel = 1'b0;

        // Read of 7 together with clear_req: read completes, then a full clear
        access(1'b0, 10'd7, 8'h00, 1'b1, 8'h5A, 1'b0);
        check("busy_after_clear_req", a_busy, 1'b1);
        check("dout_hold_in_clear", a_dout, 8'h5A);
        wait_ready("clear_req_cycles", 1024);
        access(1'b0, 10'd7,    8'h00, 1'b0, 8'h00, 1'b0);
        access(1'b0, 10'd1023, 8'h00, 1'b0, 8'h00, 1'b0);

        // Reset partway through a commanded clear
        access(1'b1, 10'd9, 8'hC3, 1'b0, 8'h00, 1'b0);
        access(1'b0, 10'd9, 8'h00, 1'b0, 8'hC3, 1'b0);
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        repeat (300) tick();
        check("dout_hold_mid_clear", a_dout, 8'hC3);
        rst_n = 1'b0;
        #2;
        check_reset_values();
        @(posedge clk);
        #1;
        release_and_count();
        access(1'b0, 10'd9, 8'h00, 1'b0, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
